// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: opcodes, funct codes,
// ALU operation codes and datapath mux selects.
package multicycle_control_pkg;

    // Instruction opcodes (instruction register bits [31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (instruction register bits [5:0])
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;

    // ALU operand selects
    localparam logic [1:0] ALU_A_PC    = 2'd0;
    localparam logic [1:0] ALU_A_RS    = 2'd1;
    localparam logic [1:0] ALU_A_SHAMT = 2'd2;
    localparam logic [1:0] ALU_B_RT    = 2'd0;
    localparam logic [1:0] ALU_B_FOUR  = 2'd1;
    localparam logic [1:0] ALU_B_IMM   = 2'd2;

    // Program counter source selects
    localparam logic [1:0] PC_SEL_INC    = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH = 2'd1;
    localparam logic [1:0] PC_SEL_JUMP   = 2'd2;

    // Memory address source, register destination and write-back source
    localparam logic MEM_ADDR_PC  = 1'b0;
    localparam logic MEM_ADDR_ALU = 1'b1;
    localparam logic DEST_RT      = 1'b0;
    localparam logic DEST_RD      = 1'b1;
    localparam logic WB_FROM_ALU  = 1'b0;
    localparam logic WB_FROM_MEM  = 1'b1;

    localparam logic [3:0] MEM_WE_WORD = 4'hF;
    localparam logic [3:0] MEM_WE_NONE = 4'h0;

endpackage

// File: rtl/alu_decoder.sv
// Combinational funct-to-ALU-operation decoder for R-type instructions.
// Also reports whether the operation is a shift (A operand is shamt)
// and whether the funct code is supported at all.
module alu_decoder
    import multicycle_control_pkg::*;
(
    input  logic [5:0] funct,
    output logic [3:0] alu_op,
    output logic       is_shift,
    output logic       valid
);

    // Map each supported funct code to its ALU operation
    always_comb begin
        alu_op   = ALU_ADD;
        is_shift = 1'b0;
        valid    = 1'b1;
        case (funct)
            FN_ADD: alu_op = ALU_ADD;
            FN_SUB: alu_op = ALU_SUB;
            FN_AND: alu_op = ALU_AND;
            FN_OR:  alu_op = ALU_OR;
            FN_SLT: alu_op = ALU_SLT;
            FN_SLL: begin
                alu_op   = ALU_SLL;
                is_shift = 1'b1;
            end
            FN_SRL: begin
                alu_op   = ALU_SRL;
                is_shift = 1'b1;
            end
            FN_SRA: begin
                alu_op   = ALU_SRA;
                is_shift = 1'b1;
            end
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor control unit. Sequences fetch, decode, memory
// access, execute and write-back for a small MIPS-like instruction set.
// Datapath controls come from the current state; mem_ready, equal and
// funct only qualify write strobes, branch decisions and the R-type ALU op.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       equal,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic [3:0] mem_we,
    output logic       mem_addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic [3:0] alu_op,
    output logic [1:0] alu_a_sel,
    output logic [1:0] alu_b_sel,
    output logic       reg_d_we,
    output logic       reg_d_addr_sel,
    output logic       reg_d_data_sel,
    output logic       illegal
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXEC_R    = 4'd7,
        EXEC_I    = 4'd8,
        ALU_WB    = 4'd9,
        HALT      = 4'd10
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic       started_q;
    logic       illegal_q;
    logic       dest_rd_q;
    logic [3:0] dec_alu_op;
    logic       dec_is_shift;
    logic       dec_valid;

    alu_decoder u_alu_decoder (
        .funct    (funct),
        .alu_op   (dec_alu_op),
        .is_shift (dec_is_shift),
        .valid    (dec_valid)
    );

    // State register; started_q holds IDLE for one extra edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
        end
    end

    // Sticky illegal flag and write-back destination captured on EXEC entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
            dest_rd_q <= DEST_RT;
        end else begin
            if (state_d == HALT) begin
                illegal_q <= 1'b1;
            end
            if (state_q == DECODE && state_d == EXEC_R) begin
                dest_rd_q <= DEST_RD;
            end else if (state_q == DECODE && state_d == EXEC_I) begin
                dest_rd_q <= DEST_RT;
            end
        end
    end

    // Next-state selection and datapath control decode
    always_comb begin
        state_d        = state_q;
        mem_req        = 1'b0;
        mem_we         = MEM_WE_NONE;
        mem_addr_sel   = MEM_ADDR_PC;
        ir_we          = 1'b0;
        pc_we          = 1'b0;
        pc_sel         = PC_SEL_INC;
        alu_op         = ALU_ADD;
        alu_a_sel      = ALU_A_PC;
        alu_b_sel      = ALU_B_RT;
        reg_d_we       = 1'b0;
        reg_d_addr_sel = DEST_RT;
        reg_d_data_sel = WB_FROM_ALU;
        case (state_q)
            IDLE: begin
                if (started_q) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                mem_req      = 1'b1;
                mem_addr_sel = MEM_ADDR_PC;
                alu_a_sel    = ALU_A_PC;
                alu_b_sel    = ALU_B_FOUR;
                alu_op       = ALU_ADD;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    pc_sel  = PC_SEL_INC;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEM_ADDR;
                    OP_RTYPE:     state_d = EXEC_R;
                    OP_ADDI:      state_d = EXEC_I;
                    OP_BEQ: begin
                        if (equal) begin
                            pc_we  = 1'b1;
                            pc_sel = PC_SEL_BRANCH;
                        end
                        state_d = FETCH;
                    end
                    OP_J: begin
                        pc_we   = 1'b1;
                        pc_sel  = PC_SEL_JUMP;
                        state_d = FETCH;
                    end
                    default: state_d = HALT;
                endcase
            end
            MEM_ADDR: begin
                alu_op    = ALU_ADD;
                alu_a_sel = ALU_A_RS;
                alu_b_sel = ALU_B_IMM;
                state_d   = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                mem_req      = 1'b1;
                mem_addr_sel = MEM_ADDR_ALU;
                if (mem_ready) begin
                    state_d = MEM_WB;
                end
            end
            MEM_WB: begin
                reg_d_we       = 1'b1;
                reg_d_addr_sel = DEST_RT;
                reg_d_data_sel = WB_FROM_MEM;
                state_d        = FETCH;
            end
            MEM_WRITE: begin
                mem_req      = 1'b1;
                mem_addr_sel = MEM_ADDR_ALU;
                mem_we       = MEM_WE_WORD;
                if (mem_ready) begin
                    state_d = FETCH;
                end
            end
            EXEC_R: begin
                if (dec_valid) begin
                    alu_op    = dec_alu_op;
                    alu_a_sel = dec_is_shift ? ALU_A_SHAMT : ALU_A_RS;
                    alu_b_sel = ALU_B_RT;
                    state_d   = ALU_WB;
                end else begin
                    state_d = HALT;
                end
            end
            EXEC_I: begin
                alu_op    = ALU_ADD;
                alu_a_sel = ALU_A_RS;
                alu_b_sel = ALU_B_IMM;
                state_d   = ALU_WB;
            end
            ALU_WB: begin
                reg_d_we       = 1'b1;
                reg_d_addr_sel = dest_rd_q;
                reg_d_data_sel = WB_FROM_ALU;
                state_d        = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: state_d = IDLE;
        endcase
    end

    assign illegal = illegal_q;

endmodule
